// File: rtl/binarize_sequencer.sv
// -----------------------------------------------------------------------------
// binarize_sequencer
//
// Phase sequencer for the image binarization datapath. One frame runs:
//   CLEAR  : one-cycle clear pulse to the 256 histogram counters
//   HIST   : stream every pixel address, counters accumulate one cycle later
//   HDRAIN : let the last pixel reach the counters
//   SEARCH : kick the CDF priority encoder, wait (bounded) for its result
//   THRESH : re-stream every pixel, write back binarized result one cycle later
//   TDRAIN : final write
//   DONE   : hold done until the next start or reset
//
// Ports
//   clk, rst_n   single clock, synchronous active-low reset
//   start        begin a frame (honoured only in IDLE or DONE)
//   busy         high in every state except IDLE and DONE
//   mem_rd_en    pixel read strobe, mem_addr its address (0 when not reading)
//   cnt_clear    histogram clear pulse; cnt_en histogram accumulate
//   enc_start    encoder kick pulse; enc_done / thresh_in encoder result
//   thresh_q     latched threshold (128 after an encoder timeout)
//   we, wr_addr  write-back strobe and address (wr_addr is 0 when we is low)
//   done         frame complete; error sticky encoder timeout for this frame
//
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module binarize_sequencer #(
  parameter int NUM_PIXELS  = 65536,
  parameter int ADDR_W      = 16,
  parameter int ENC_TIMEOUT = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              cnt_clear,
  output logic              cnt_en,
  output logic              enc_start,
  input  logic              enc_done,
  input  logic [7:0]        thresh_in,
  output logic [7:0]        thresh_q,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_HIST, S_HDRAIN, S_SEARCH, S_THRESH, S_TDRAIN, S_DONE
  } state_t;

  localparam int                WAIT_W    = $clog2(ENC_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(ENC_TIMEOUT - 1);
  localparam logic [7:0]        FALLBACK_THRESH = 8'd128;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;       // next pixel address of the current pass
  logic [WAIT_W-1:0]   r_wait;      // SEARCH cycles already spent
  logic                r_busy;
  logic                r_mem_rd_en;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_cnt_clear;
  logic                r_cnt_en;
  logic                r_enc_start;
  logic [7:0]          r_thresh_q;
  logic                r_we;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_done;
  logic                r_error;

  // Read data lands one cycle after the strobe, so the consumer of each pass
  // is enabled from the previous cycle's strobe, qualified by which pass it was.
  logic w_hist_pass;
  logic w_thresh_pass;
  assign w_hist_pass   = (r_state == S_HIST)   || (r_state == S_HDRAIN);
  assign w_thresh_pass = (r_state == S_THRESH) || (r_state == S_TDRAIN);

  // NOTE: all state is updated with non-blocking assignments so every
  // right-hand side sees the pre-edge value, exactly like the flops it models.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_cnt_clear <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_enc_start <= 1'b0;
      r_thresh_q  <= '0;
      r_we        <= 1'b0;
      r_wr_addr   <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // Pulse-type outputs default low; states below raise them as needed.
      r_cnt_clear <= 1'b0;
      r_enc_start <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;

      r_cnt_en  <= r_mem_rd_en && w_hist_pass;
      r_we      <= r_mem_rd_en && w_thresh_pass;
      r_wr_addr <= (r_mem_rd_en && w_thresh_pass) ? r_mem_addr : '0;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_CLEAR;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_thresh_q <= '0;
          end
        end

        S_CLEAR: begin
          r_cnt_clear <= 1'b1;
          r_idx       <= '0;
          r_state     <= S_HIST;
        end

        S_HIST, S_THRESH: begin
          r_mem_rd_en <= 1'b1;
          r_mem_addr  <= r_idx;
          if (r_idx == LAST_ADDR) begin
            r_state <= (r_state == S_HIST) ? S_HDRAIN : S_TDRAIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_HDRAIN: begin
          r_wait  <= '0;
          r_state <= S_SEARCH;
        end

        S_SEARCH: begin
          r_enc_start <= (r_wait == '0);
          // A result arriving on the timeout cycle itself still counts.
          if (enc_done) begin
            r_thresh_q <= thresh_in;
            r_idx      <= '0;
            r_state    <= S_THRESH;
          end else if (r_wait == LAST_WAIT) begin
            r_error    <= 1'b1;
            r_thresh_q <= FALLBACK_THRESH;
            r_idx      <= '0;
            r_state    <= S_THRESH;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_TDRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign cnt_clear = r_cnt_clear;
  assign cnt_en    = r_cnt_en;
  assign enc_start = r_enc_start;
  assign thresh_q  = r_thresh_q;
  assign we        = r_we;
  assign wr_addr   = r_wr_addr;
  assign done      = r_done;
  assign error     = r_error;

endmodule
